// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg: shared types and constants for the BIST sequencer slice.
//   - bist_state_t  : sequencer state encoding (3 bits)
//   - TIMEOUT_CYC_DEFAULT : default watchdog limit in WAIT cycles
//   - bist_result_t : per-engine result record {fail, timeout}
// ----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    RECORD  = 3'd4,
    ADVANCE = 3'd5,
    FINISH  = 3'd6
  } bist_state_t;

  localparam int          TIMEOUT_W_DEFAULT   = 16;
  localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'hFFFF;

  typedef struct packed {
    logic fail;
    logic timeout;
  } bist_result_t;

endpackage

// File: rtl/bist_watchdog.sv
// ----------------------------------------------------------------------------
// bist_watchdog: loadable up-counter used to bound the time an engine may
// spend in WAIT.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear to zero (highest priority after rst)
//   load       : load load_val into the counter
//   load_val   : value loaded when load is high
//   en         : count enable
//   tc         : terminal count, high while count == TIMEOUT_CYC-1
// ----------------------------------------------------------------------------
module bist_watchdog #(
  parameter int                   TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = {TIMEOUT_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  input  logic                 en,
  output logic                 tc
);

  logic [TIMEOUT_W-1:0] count;

  // Counter register: clear > load > increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + TIMEOUT_W'(1);
    end else begin
      count <= count;
    end
  end

  // Count starts at 0 on the first WAIT cycle, so TIMEOUT_CYC-1 marks the
  // TIMEOUT_CYC-th WAIT cycle.
  assign tc = (count == (TIMEOUT_CYC - TIMEOUT_W'(1)));

endmodule

// File: rtl/bist_sequencer.sv
// ----------------------------------------------------------------------------
// bist_sequencer: runs up to NUM_MEM per-memory BIST engines one at a time in
// ascending index order, records each engine's sticky error flag, catches hung
// engines with a watchdog and reports summary pass/fail plus per-engine vectors.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   run          : one-cycle request to start a sequence (ignored while busy)
//   mem_mask     : engine select mask, sampled when run is accepted
//   bist_start   : one-hot start pulse to the engine under test
//   bist_done    : per-engine done (high when idle)
//   bist_status  : per-engine sticky error flag
//   busy         : sequence in progress
//   all_done     : one-cycle pulse at sequence completion
//   pass         : no selected engine failed or timed out (held)
//   fail_vec     : per-engine error results (held)
//   timeout_vec  : per-engine watchdog results (held)
//   cur_idx      : engine currently selected / under test
//
// Build option: define BIST_SEQ_STOP_ON_FAIL_EN to end the sequence at the
// first recorded failure or timeout; otherwise every selected engine runs.
// ----------------------------------------------------------------------------
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int                   NUM_MEM     = 4,
  parameter int                   IDX_W       = 2,
  parameter int                   TIMEOUT_W   = TIMEOUT_W_DEFAULT,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(TIMEOUT_CYC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [NUM_MEM-1:0] mem_mask,
  output logic [NUM_MEM-1:0] bist_start,
  input  logic [NUM_MEM-1:0] bist_done,
  input  logic [NUM_MEM-1:0] bist_status,
  output logic               busy,
  output logic               all_done,
  output logic               pass,
  output logic [NUM_MEM-1:0] fail_vec,
  output logic [NUM_MEM-1:0] timeout_vec,
  output logic [IDX_W-1:0]   cur_idx
);

  bist_state_t                     state;
  logic         [NUM_MEM-1:0]      mask;
  logic         [NUM_MEM-1:0]      start_r;
  bist_result_t [NUM_MEM-1:0]      res;
  logic                            last_idx;
  logic                            wd_clr;
  logic                            wd_en;
  logic                            wd_tc;

  assign last_idx = (cur_idx == IDX_W'(NUM_MEM - 1));
  assign wd_clr   = (state == START);
  assign wd_en    = (state == WAIT);

  // Reset kills the start pulse in the same cycle so no engine is launched
  // while the sequencer is being reset.
  assign bist_start = rst ? '0 : start_r;

  for (genvar g = 0; g < NUM_MEM; g++) begin : g_res
    assign fail_vec[g]    = res[g].fail;
    assign timeout_vec[g] = res[g].timeout;
  end

  bist_watchdog #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wd_en),
    .tc       (wd_tc)
  );

  // Sequencer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      start_r  <= '0;
      res      <= '0;
      cur_idx  <= '0;
      busy     <= 1'b0;
      all_done <= 1'b0;
      pass     <= 1'b0;
    end else begin
      start_r  <= '0;
      all_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            mask    <= mem_mask;
            res     <= '0;
            pass    <= 1'b1;
            cur_idx <= '0;
            busy    <= 1'b1;
            state   <= SELECT;
          end
        end
        SELECT: begin
          if (mask[cur_idx]) begin
            for (int i = 0; i < NUM_MEM; i++) begin
              start_r[i] <= (cur_idx == IDX_W'(i));
            end
            state <= START;
          end else if (last_idx) begin
            all_done <= 1'b1;
            state    <= FINISH;
          end else begin
            cur_idx <= cur_idx + IDX_W'(1);
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // done has priority over a simultaneous watchdog expiry
          if (bist_done[cur_idx]) begin
            state <= RECORD;
          end else if (wd_tc) begin
            res[cur_idx].timeout <= 1'b1;
            pass                 <= 1'b0;
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
            all_done <= 1'b1;
            state    <= FINISH;
`else
            state <= ADVANCE;
`endif
          end
        end
        RECORD: begin
          res[cur_idx].fail <= bist_status[cur_idx];
          if (bist_status[cur_idx]) begin
            pass <= 1'b0;
          end
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
          if (bist_status[cur_idx]) begin
            all_done <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= ADVANCE;
          end
`else
          state <= ADVANCE;
`endif
        end
        ADVANCE: begin
          if (last_idx) begin
            all_done <= 1'b1;
            state    <= FINISH;
          end else begin
            cur_idx <= cur_idx + IDX_W'(1);
            state   <= SELECT;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bist_sequencer: self-checking bench for bist_sequencer (NUM_MEM=4,
// watchdog limit 64). Behavioural engine models drive bist_done/bist_status;
// a sequence-level reference model predicts start order, result vectors, pass
// and the run-to-all_done latency.
// ----------------------------------------------------------------------------
module tb_bist_sequencer;

  localparam int NM = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [NM-1:0] mem_mask;
  logic [NM-1:0] bist_start;
  logic [NM-1:0] bist_done;
  logic [NM-1:0] bist_status;
  logic          busy;
  logic          all_done;
  logic          pass;
  logic [NM-1:0] fail_vec;
  logic [NM-1:0] timeout_vec;
  logic [1:0]    cur_idx;

  bist_sequencer #(
    .NUM_MEM     (NM),
    .IDX_W       (2),
    .TIMEOUT_W   (16),
    .TIMEOUT_CYC (16'd64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem_mask    (mem_mask),
    .bist_start  (bist_start),
    .bist_done   (bist_done),
    .bist_status (bist_status),
    .busy        (busy),
    .all_done    (all_done),
    .pass        (pass),
    .fail_vec    (fail_vec),
    .timeout_vec (timeout_vec),
    .cur_idx     (cur_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: done drops on the cycle after start, stays low for
  // eng_lat cycles, then returns high. A hung engine never returns.
  logic [NM-1:0] eng_done;
  logic [NM-1:0] eng_hang;
  logic [NM-1:0] eng_status;
  logic          eng_clr;
  int            eng_lat [NM];
  int            eng_cnt [NM];

  always @(posedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (eng_clr) begin
        eng_done[i] <= 1'b1;
        eng_cnt[i]  <= 0;
      end else if (bist_start[i]) begin
        eng_done[i] <= 1'b0;
        eng_cnt[i]  <= eng_lat[i];
      end else if (!eng_done[i] && !eng_hang[i]) begin
        if (eng_cnt[i] <= 1) eng_done[i] <= 1'b1;
        eng_cnt[i] <= eng_cnt[i] - 1;
      end
    end
  end

  assign bist_done   = eng_done;
  assign bist_status = eng_status;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    int idx = 99;
    int n   = 0;
    for (int i = 0; i < NM; i++) begin
      if (v[i]) begin
        idx = i;
        n++;
      end
    end
    return (n == 1) ? idx : 99;
  endfunction

  // Reference model: walks the engines as the sequence rules describe.
  int            exp_q [$];
  logic [NM-1:0] exp_fail;
  logic [NM-1:0] exp_to;
  logic          exp_pass;
  int            exp_lat;

  task automatic model(input logic [NM-1:0] m);
    bit stop = 0;
    exp_q.delete();
    exp_fail = '0;
    exp_to   = '0;
    exp_lat  = 1;                       // FINISH cycle carrying all_done
    for (int i = 0; i < NM; i++) begin
      if (!stop) begin
        if (!m[i]) begin
          exp_lat += 1;                 // one SELECT cycle
        end else begin
          exp_q.push_back(i);
          if (eng_hang[i]) begin
            exp_to[i] = 1'b1;
            exp_lat  += 3 + TO;         // SELECT, START, TO waits, ADVANCE
          end else begin
            exp_fail[i] = eng_status[i];
            exp_lat    += eng_lat[i] + 5; // SELECT, START, lat+1 waits, RECORD, ADVANCE
          end
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
          if (exp_to[i] || exp_fail[i]) begin
            stop = 1;
            exp_lat -= 1;               // goes straight to FINISH, no ADVANCE
          end
`endif
        end
      end
    end
    exp_pass = ((exp_fail | exp_to) == '0);
  endtask

  // Runs one full sequence and compares it with the reference model.
  task automatic run_seq(input logic [NM-1:0] m, input string tag);
    int q [$];
    int c0;
    int lat_meas = -1;
    bit seen = 0;
    model(m);
    @(negedge clk);
    eng_clr = 1'b1;
    @(negedge clk);
    eng_clr  = 1'b0;
    mem_mask = m;
    run      = 1'b1;
    c0       = cyc;
    @(negedge clk);
    run      = 1'b0;
    mem_mask = ~m;                      // must not affect the latched mask
    check({tag, " busy_after_run"}, busy, 1);
    for (int k = 0; k < 3000; k++) begin
      if (bist_start != '0) q.push_back(onehot_idx(bist_start));
      if (all_done) begin
        seen     = 1;
        lat_meas = cyc - c0;
        break;
      end
      run = (k == 2);                   // a run while busy is ignored
      @(negedge clk);
    end
    run = 1'b0;
    check({tag, " all_done_seen"}, seen, 1);
    check({tag, " latency"}, lat_meas, exp_lat);
    check({tag, " start_count"}, q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++)
      check({tag, " start_order"}, q[i], exp_q[i]);
    check({tag, " fail_vec"}, fail_vec, exp_fail);
    check({tag, " timeout_vec"}, timeout_vec, exp_to);
    check({tag, " pass"}, pass, exp_pass);
    @(negedge clk);
    check({tag, " busy_cleared"}, busy, 0);
    check({tag, " all_done_one_cycle"}, all_done, 0);
  endtask

  typedef struct {
    logic [NM-1:0] mask;
    logic [NM-1:0] status;
    logic [NM-1:0] hang;
    int            lat;
    logic [NM-1:0] exp_fail;
    logic [NM-1:0] exp_to;
    logic          exp_pass;
    int            exp_cyc;
  } vec_t;

  vec_t tab [5];

  initial begin
    tab[0] = '{4'b1111, 4'b0000, 4'b0000, 20, 4'b0000, 4'b0000, 1'b1, 101};
    tab[3] = '{4'b0000, 4'b0000, 4'b0000, 20, 4'b0000, 4'b0000, 1'b1, 5};
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
    tab[1] = '{4'b1010, 4'b1000, 4'b0000, 20, 4'b1000, 4'b0000, 1'b0, 52};
    tab[2] = '{4'b1111, 4'b0000, 4'b0100, 20, 4'b0000, 4'b0100, 1'b0, 117};
    tab[4] = '{4'b1111, 4'b0001, 4'b0000, 20, 4'b0001, 4'b0000, 1'b0, 25};
`else
    tab[1] = '{4'b1010, 4'b1000, 4'b0000, 20, 4'b1000, 4'b0000, 1'b0, 53};
    tab[2] = '{4'b1111, 4'b0000, 4'b0100, 20, 4'b0000, 4'b0100, 1'b0, 143};
    tab[4] = '{4'b1111, 4'b0001, 4'b0000, 20, 4'b0001, 4'b0000, 1'b0, 101};
`endif

    rst        = 1'b1;
    run        = 1'b0;
    mem_mask   = '0;
    eng_clr    = 1'b1;
    eng_hang   = '0;
    eng_status = '0;
    for (int i = 0; i < NM; i++) eng_lat[i] = 20;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset all_done", all_done, 0);
    check("reset pass", pass, 0);
    check("reset fail_vec", fail_vec, 0);
    check("reset timeout_vec", timeout_vec, 0);
    check("reset cur_idx", cur_idx, 0);
    check("reset bist_start", bist_start, 0);
    rst     = 1'b0;
    eng_clr = 1'b0;

    // Directed table
    for (int t = 0; t < 5; t++) begin
      eng_status = tab[t].status;
      eng_hang   = tab[t].hang;
      for (int i = 0; i < NM; i++) eng_lat[i] = tab[t].lat;
      run_seq(tab[t].mask, $sformatf("tab%0d", t));
      check($sformatf("tab%0d exp_cycles", t), exp_lat, tab[t].exp_cyc);
      check($sformatf("tab%0d tab_fail", t), fail_vec, tab[t].exp_fail);
      check($sformatf("tab%0d tab_timeout", t), timeout_vec, tab[t].exp_to);
      check($sformatf("tab%0d tab_pass", t), pass, tab[t].exp_pass);
      repeat (3) @(negedge clk);
      check($sformatf("tab%0d held_fail", t), fail_vec, tab[t].exp_fail);
    end

    // Reset while waiting on engine 1
    eng_status = '0;
    eng_hang   = '0;
    for (int i = 0; i < NM; i++) eng_lat[i] = 20;
    @(negedge clk);
    eng_clr = 1'b1;
    @(negedge clk);
    eng_clr  = 1'b0;
    mem_mask = 4'b1111;
    run      = 1'b1;
    @(negedge clk);
    run = 1'b0;
    begin
      bit got = 0;
      for (int k = 0; k < 200 && !got; k++) begin
        if (bist_start[1]) got = 1;
        else @(negedge clk);
      end
      check("rst_wait start1_seen", got, 1);
    end
    repeat (3) @(negedge clk);
    check("rst_wait busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait busy", busy, 0);
    check("rst_wait bist_start", bist_start, 0);
    check("rst_wait pass", pass, 0);
    check("rst_wait vectors", {fail_vec, timeout_vec}, 0);
    check("rst_wait cur_idx", cur_idx, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Reset during the START cycle must drop bist_start at once
    eng_clr = 1'b1;
    @(negedge clk);
    eng_clr  = 1'b0;
    mem_mask = 4'b0001;
    run      = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("rst_start pulse_present", bist_start, 4'b0001);
    rst = 1'b1;
    #1;
    check("rst_start pulse_dropped", bist_start, 0);
    @(negedge clk);
    rst = 1'b0;
    run_seq(4'b1111, "restart");

    // Randomized sequences against the reference model
    for (int r = 0; r < 12; r++) begin
      eng_status = NM'($urandom);
      for (int i = 0; i < NM; i++) begin
        eng_hang[i] = ($urandom_range(0, 7) == 0);
        eng_lat[i]  = $urandom_range(1, 20);
      end
      run_seq(NM'($urandom_range(0, 15)), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
